// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control sequencer.
package stopwatch_pkg;

  localparam int COUNT_W   = 14;
  localparam int BTN_START = 0;
  localparam int BTN_LAP   = 1;
  localparam int BTN_CLEAR = 2;

  // Encodings double as the one-hot LED pattern.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_RUN   = 4'b0010,
    ST_LAP   = 4'b0100,
    ST_PAUSE = 4'b1000
  } state_t;

  function automatic logic is_counting(input state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button lane: 2-flop synchronizer, stability counter and a
// one-cycle press pulse on the debounced released-to-pressed transition.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic             flip;
  logic [CNT_W-1:0] cnt;

  // Keys are active-low; the synchronizer carries "pressed" polarity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= ~key;
      sync_p1 <= sync_p0;
    end
  end

  assign flip = (sync_p1 != level) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      if ((sync_p1 == level) || flip) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (flip) begin
        level <= sync_p1;
      end
      press <= flip && sync_p1;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: debounced keys, start/pause/lap/clear FSM and
// tick prescaler. Define STOPWATCH_AUTO_STOP_EN to pause at TICK_MAX ticks.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ          = 50000000,
  parameter int TICK_HZ         = 100,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_MAX        = 9999
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] botoes,
  output logic       tick,
  output logic       clear,
  output logic       freeze,
  output logic [3:0] led
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [2:0]       press;
  state_t           state;
  state_t           state_nxt;
  logic             clear_nxt;
  logic             at_max;
  logic             advance;
  logic             wrap;
  logic [PRE_W-1:0] pre_cnt;
  logic             unused_key;

  assign unused_key = botoes[3];

  for (genvar i = 0; i < 3; i++) begin : g_key
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .key  (botoes[i]),
      .press(press[i])
    );
  end

  // Per state, the highest-priority event that is legal there wins.
  always_comb begin
    state_nxt = state;
    clear_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (press[BTN_CLEAR]) begin
          clear_nxt = 1'b1;
        end else if (press[BTN_START]) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (at_max || press[BTN_START]) begin
          state_nxt = ST_PAUSE;
        end else if (press[BTN_LAP]) begin
          state_nxt = ST_LAP;
        end
      end
      ST_LAP: begin
        if (at_max || press[BTN_START]) begin
          state_nxt = ST_PAUSE;
        end else if (press[BTN_LAP]) begin
          state_nxt = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (press[BTN_CLEAR]) begin
          state_nxt = ST_IDLE;
          clear_nxt = 1'b1;
        end else if (press[BTN_START] && !at_max) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Only advance when counting both now and next, so leaving RUN never ticks.
  assign advance = is_counting(state) && is_counting(state_nxt);
  assign wrap    = advance && (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      clear   <= 1'b0;
      tick    <= 1'b0;
      pre_cnt <= '0;
    end else begin
      state <= state_nxt;
      clear <= clear_nxt;
      tick  <= wrap;
      if (state_nxt == ST_IDLE) begin
        pre_cnt <= '0;
      end else if (advance) begin
        pre_cnt <= wrap ? '0 : pre_cnt + PRE_W'(1);
      end
    end
  end

`ifdef STOPWATCH_AUTO_STOP_EN
  logic [COUNT_W-1:0] tally;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tally <= '0;
    end else if (clear_nxt) begin
      tally <= '0;
    end else if (wrap) begin
      tally <= tally + COUNT_W'(1);
    end
  end

  assign at_max = (tally == COUNT_W'(TICK_MAX));
`else
  logic [COUNT_W-1:0] unused_tick_max;

  assign unused_tick_max = COUNT_W'(TICK_MAX);
  assign at_max          = 1'b0;
`endif

  assign led    = state;
  assign freeze = (state == ST_LAP);

endmodule
